// File: rtl/instr_encoder_loader.sv
// =============================================================================
// Module      : instr_encoder_loader
// Description : Packs RV32I fields plus an immediate into instruction words,
//               range-checks the immediate and streams legal words into memory.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_range,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   instr_count,
  output logic              full
);

  localparam logic [2:0] c_fmt_r = 3'd0;
  localparam logic [2:0] c_fmt_i = 3'd1;
  localparam logic [2:0] c_fmt_s = 3'd2;
  localparam logic [2:0] c_fmt_b = 3'd3;
  localparam logic [2:0] c_fmt_u = 3'd4;
  localparam logic [2:0] c_fmt_j = 3'd5;

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last = {ADDR_W{1'b1}};

  logic              mem_we_q,      mem_we_d;
  logic              err_range_q,   err_range_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [31:0]       mem_wdata_q,   mem_wdata_d;
  logic [ADDR_W-1:0] ptr_q,         ptr_d;
  logic [7:0]        err_count_q,   err_count_d;
  logic [ADDR_W:0]   instr_count_q, instr_count_d;
  logic              full_q,        full_d;

  logic        accept;
  logic        imm_fits12;
  logic        imm_fits13;
  logic        imm_fits21;
  logic        enc_legal;
  logic [31:0] enc_word;

  assign in_ready = ~full_q;
  assign accept   = in_valid & ~full_q;

  // An immediate fits an N-bit signed field when bits [31:N-1] are all equal.
  assign imm_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign imm_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (in_fmt)
      c_fmt_r: begin
        enc_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = 1'b1;
      end
      c_fmt_i: begin
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_legal = imm_fits12;
      end
      c_fmt_s: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_legal = imm_fits12;
      end
      c_fmt_b: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_legal = imm_fits13 & ~in_imm[0];
      end
      c_fmt_u: begin
        enc_word  = {in_imm[31:12], in_rd, in_opcode};
        enc_legal = ~(|in_imm[11:0]);
      end
      c_fmt_j: begin
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                     in_rd, in_opcode};
        enc_legal = imm_fits21 & ~in_imm[0];
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_we_d      = 1'b0;
    err_range_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    ptr_d         = ptr_q;
    err_count_d   = err_count_q;
    instr_count_d = instr_count_q;
    full_d        = full_q;
    // Clear takes priority over a same-cycle accept, so the request is dropped.
    if (clear) begin
      mem_addr_d    = c_base;
      ptr_d         = c_base;
      err_count_d   = '0;
      instr_count_d = '0;
      full_d        = 1'b0;
    end else if (accept) begin
      if (enc_legal) begin
        mem_we_d      = 1'b1;
        mem_addr_d    = ptr_q;
        mem_wdata_d   = enc_word;
        instr_count_d = instr_count_q + (ADDR_W + 1)'(1);
        if (ptr_q == c_last) begin
          full_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end else begin
        err_range_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q      <= 1'b0;
      err_range_q   <= 1'b0;
      mem_addr_q    <= c_base;
      mem_wdata_q   <= '0;
      ptr_q         <= c_base;
      err_count_q   <= '0;
      instr_count_q <= '0;
      full_q        <= 1'b0;
    end else begin
      mem_we_q      <= mem_we_d;
      err_range_q   <= err_range_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      ptr_q         <= ptr_d;
      err_count_q   <= err_count_d;
      instr_count_q <= instr_count_d;
      full_q        <= full_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign err_range   = err_range_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_count   = err_count_q;
  assign instr_count = instr_count_q;
  assign full        = full_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// =============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed and randomized checks of instr_encoder_loader against
//               an arithmetic reference model (8-bit and 2-bit address builds).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear_a, clear_b, valid_a, valid_b;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  logic        ready_a, we_a, err_a, full_a;
  logic [7:0]  addr_a, errc_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;

  logic        ready_b, we_b, err_b, full_b;
  logic [1:0]  addr_b;
  logic [7:0]  errc_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_fmt(fmt), .in_opcode(opcode), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
    .in_funct3(f3), .in_funct7(f7), .in_imm(imm),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .err_range(err_a),
    .err_count(errc_a), .instr_count(cnt_a), .full(full_a)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_fmt(fmt), .in_opcode(opcode), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
    .in_funct3(f3), .in_funct7(f7), .in_imm(imm),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .err_range(err_b),
    .err_count(errc_b), .instr_count(cnt_b), .full(full_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = 256-word build, index 1 = 4-word build.
  int          m_ptr[2], m_cnt[2], m_err[2], m_addr[2];
  bit          m_full[2], m_we[2], m_rng[2];
  logic [31:0] m_wdata[2];
  int          last_addr[2] = '{255, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word built with shifts/masks and legality from signed integer ranges.
  function automatic void ref_encode(output bit legal, output logic [31:0] w);
    longint      s;
    logic [31:0] u, lo;
    s  = longint'($signed(imm));
    u  = imm;
    lo = (32'(rd) << 7) | 32'(opcode);
    legal = 1'b0;
    w = '0;
    case (fmt)
      3'd0: begin
        legal = 1'b1;
        w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | lo;
      end
      3'd1: begin
        legal = (s >= -2048) && (s <= 2047);
        w = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | lo;
      end
      3'd2: begin
        legal = (s >= -2048) && (s <= 2047);
        w = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
          | (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'(opcode);
      end
      3'd3: begin
        legal = (s >= -4096) && (s <= 4094) && (u[0] == 1'b0);
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
          | (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8)
          | (((u >> 11) & 32'h1) << 7) | 32'(opcode);
      end
      3'd4: begin
        legal = (u & 32'hFFF) == 32'h0;
        w = (u & 32'hFFFFF000) | lo;
      end
      3'd5: begin
        legal = (s >= -1048576) && (s <= 1048574) && (u[0] == 1'b0);
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
          | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | lo;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  // Advance the model with the inputs now applied, clock once, compare everything.
  task automatic step();
    bit          lg, v, c;
    logic [31:0] wd;
    ref_encode(lg, wd);
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? valid_a : valid_b;
      c = (i == 0) ? clear_a : clear_b;
      m_we[i]  = 1'b0;
      m_rng[i] = 1'b0;
      if (!rst_n) begin
        m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 1'b0;
        m_addr[i] = 0; m_wdata[i] = '0;
      end else if (c) begin
        m_ptr[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 1'b0; m_addr[i] = 0;
      end else if (v && !m_full[i]) begin
        if (lg) begin
          m_we[i] = 1'b1; m_addr[i] = m_ptr[i]; m_wdata[i] = wd; m_cnt[i]++;
          if (m_ptr[i] == last_addr[i]) m_full[i] = 1'b1;
          else m_ptr[i]++;
        end else begin
          m_rng[i] = 1'b1;
          if (m_err[i] < 255) m_err[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("a_we", we_a, m_we[0]);          chk("b_we", we_b, m_we[1]);
    chk("a_err_range", err_a, m_rng[0]); chk("b_err_range", err_b, m_rng[1]);
    chk("a_addr", addr_a, m_addr[0]);    chk("b_addr", addr_b, m_addr[1]);
    chk("a_wdata", wdata_a, m_wdata[0]); chk("b_wdata", wdata_b, m_wdata[1]);
    chk("a_err_count", errc_a, m_err[0]); chk("b_err_count", errc_b, m_err[1]);
    chk("a_instr_count", cnt_a, m_cnt[0]); chk("b_instr_count", cnt_b, m_cnt[1]);
    chk("a_full", full_a, m_full[0]);    chk("b_full", full_b, m_full[1]);
    chk("a_ready", ready_a, !m_full[0]); chk("b_ready", ready_b, !m_full[1]);
  endtask

  task automatic set_req(input logic [2:0] t_fmt, input logic [6:0] t_op, input logic [4:0] t_rd,
                         input logic [4:0] t_rs1, input logic [4:0] t_rs2, input logic [2:0] t_f3,
                         input logic [31:0] t_imm);
    fmt = t_fmt; opcode = t_op; rd = t_rd; rs1 = t_rs1; rs2 = t_rs2; f3 = t_f3; imm = t_imm;
    f7 = 7'h00;
  endtask

  int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, 1048576, -1048576, -1048578};

  initial begin
    rst_n = 1'b0; clear_a = 1'b0; clear_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    set_req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);

    // Reset state
    step(); step();
    chk("rst_we", we_a, 1'b0);
    chk("rst_wdata", wdata_a, 32'h0);
    rst_n = 1'b1;
    step();

    // addi x1,x0,5
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    valid_a = 1'b1;
    step();
    chk("t1_we", we_a, 1'b1);
    chk("t1_addr", addr_a, 8'd0);
    chk("t1_wdata", wdata_a, 32'h00500093);
    valid_a = 1'b0;
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;

    // sw x2,8(x1) then beq x0,x0,-4 back-to-back
    valid_a = 1'b1;
    set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
    step();
    chk("t2_sw_addr", addr_a, 8'd0);
    chk("t2_sw_wdata", wdata_a, 32'h0020A423);
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4);
    step();
    chk("t2_beq_addr", addr_a, 8'd1);
    chk("t2_beq_wdata", wdata_a, 32'hFE000EE3);
    valid_a = 1'b0;
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;

    // lui x5,0x12345000 ; jal x0,0
    valid_a = 1'b1;
    set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
    step();
    chk("t3_lui_wdata", wdata_a, 32'h123452B7);
    set_req(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    step();
    chk("t3_jal_wdata", wdata_a, 32'h0000006F);
    chk("t3_count", cnt_a, 9'd2);

    // Rejections: I imm=2048, B imm=3, fmt=7
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    step();
    chk("t4_i_err", err_a, 1'b1);
    set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
    step();
    chk("t4_b_we", we_a, 1'b0);
    set_req(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    step();
    chk("t4_err_count", errc_a, 8'd3);
    chk("t4_addr_held", addr_a, 8'd1);
    valid_a = 1'b0;
    step();

    // 4-word build fills up, ignores a fifth request, then clears
    valid_b = 1'b1;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    for (int k = 0; k < 4; k++) step();
    chk("t5_full", full_b, 1'b1);
    chk("t5_ready", ready_b, 1'b0);
    chk("t5_last_addr", addr_b, 2'd3);
    step();
    chk("t5_fifth_we", we_b, 1'b0);
    chk("t5_count", cnt_b, 3'd4);
    valid_b = 1'b0;
    clear_b = 1'b1;
    step();
    chk("t5_clr_addr", addr_b, 2'd0);
    chk("t5_clr_ready", ready_b, 1'b1);
    clear_b = 1'b0;

    // Clear beats same-cycle accept
    valid_a = 1'b1; clear_a = 1'b1;
    step();
    chk("t6_clear_beats_we", we_a, 1'b0);
    clear_a = 1'b0;
    // Accept, then reset the following cycle
    step();
    chk("t6_accept_we", we_a, 1'b1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_we", we_a, 1'b0);
    chk("t6_rst_wdata", wdata_a, 32'h0);
    chk("t6_rst_count", cnt_a, 9'd0);
    valid_a = 1'b0;
    rst_n = 1'b1;
    step();

    // Randomized traffic on both builds
    for (int n = 0; n < 400; n++) begin
      valid_a = ($urandom_range(0, 3) != 0);
      valid_b = ($urandom_range(0, 2) != 0);
      clear_a = ($urandom_range(0, 40) == 0);
      clear_b = ($urandom_range(0, 12) == 0);
      fmt    = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
      rs2    = 5'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
      case ($urandom_range(0, 5))
        0: imm = $urandom;
        1: imm = $urandom_range(0, 4095) - 32'd2048;
        2: imm = $urandom_range(0, 8191) - 32'd4096;
        3: imm = $urandom & 32'hFFFFF000;
        4: imm = $urandom_range(0, 2097151) - 32'd1048576;
        default: imm = bnd[$urandom_range(0, 11)];
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
